// File: rtl/simproc_run_ctrl.sv
// Run controller for a small simulated processor: host commands load memory,
// set the start PC, run the core with a cycle timeout, and report status.
module simproc_run_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [7:0]  proc_mem_addr,
  input  logic [7:0]  proc_mem_din,
  input  logic        proc_mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic [7:0]  pc_set_val,
  output logic        pc_set_wr,
  output logic        run,
  input  logic        halt,
  input  logic        done,
  output logic        busy,
  output logic        finished,
  output logic        timed_out,
  output logic [15:0] cycle_count,
  output logic [7:0]  instr_count
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_SETPC, S_RUN, S_FIN, S_TOUT} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  state_t     state, state_nxt;
  logic [7:0] addr_q, data_q;
  logic       cmd_fire;

  assign cmd_fire = cmd_valid & cmd_ready;

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Address/data are only observable in WR and SETPC, so capturing on any
  // accepted IDLE command is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else if (state == S_IDLE && cmd_fire) begin
      addr_q <= cmd_addr;
      data_q <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= 16'h0000;
      instr_count <= 8'h00;
    end else if (state == S_SETPC) begin
      cycle_count <= 16'h0000;
      instr_count <= 8'h00;
    end else if (state == S_RUN) begin
      if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
      if (done && instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
    end
  end

  // NOTE: next state defaults to the current state first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_fire && cmd_op == OP_WRITE)      state_nxt = S_WR;
        else if (cmd_fire && cmd_op == OP_START) state_nxt = S_SETPC;
      end
      S_WR:    state_nxt = S_IDLE;
      S_SETPC: state_nxt = S_RUN;
      S_RUN: begin
        // halt is checked first so a halting program never reports a timeout
        if (halt)                                state_nxt = S_FIN;
        else if (cycle_count == TIMEOUT_LAST)    state_nxt = S_TOUT;
        else if (cmd_fire && cmd_op == OP_ABORT) state_nxt = S_TOUT;
      end
      S_FIN, S_TOUT: begin
        if (cmd_fire && cmd_op == OP_CLEAR)      state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    mem_addr   = 8'h00;
    mem_din    = 8'h00;
    mem_we     = 1'b0;
    pc_set_val = 8'h00;
    pc_set_wr  = 1'b0;
    run        = 1'b0;
    busy       = 1'b0;
    finished   = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      S_IDLE: cmd_ready = ~rst;
      S_WR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_din  = data_q;
      end
      S_SETPC: begin
        busy       = 1'b1;
        pc_set_wr  = 1'b1;
        pc_set_val = addr_q;
      end
      S_RUN: begin
        cmd_ready = ~rst;
        busy      = 1'b1;
        run       = 1'b1;
        mem_addr  = proc_mem_addr;
        mem_din   = proc_mem_din;
        mem_we    = proc_mem_we;
      end
      S_FIN: begin
        cmd_ready = ~rst;
        finished  = 1'b1;
      end
      S_TOUT: begin
        cmd_ready = ~rst;
        timed_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simproc_run_ctrl.sv
// Bench for simproc_run_ctrl: table vectors, directed corner sequences and
// random stimulus against a behavioural model, on two TIMEOUT settings.
module tb_simproc_run_ctrl;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic       pwe;
    logic [7:0] pa;
    logic [7:0] pd;
    logic       halt;
    logic       done;
  } in_t;

  typedef struct packed {
    logic        cmd_ready;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  pc_set_val;
    logic        pc_set_wr;
    logic        run;
    logic        busy;
    logic        finished;
    logic        timed_out;
    logic [15:0] cycle_count;
    logic [7:0]  instr_count;
  } out_t;

  typedef struct {
    in_t        stim;
    logic       ready;
    logic       we;
    logic [7:0] maddr;
    logic [7:0] mdin;
    logic       busy;
    logic       run;
  } vec_t;

  typedef enum {P_IDLE, P_WRITING, P_SETTING, P_RUNNING, P_HALTED, P_EXPIRED} phase_t;

  typedef struct {
    phase_t     ph;
    logic [7:0] addr;
    logic [7:0] data;
    int         cycles;
    int         instrs;
  } model_t;

  localparam int TMO_A = 20;
  localparam int TMO_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  cur;
  out_t out_a, out_b;
  model_t ma, mb;
  int n_checks = 0;
  int n_errors = 0;

  logic        a_cmd_ready, a_mem_we, a_pc_set_wr, a_run, a_busy, a_finished, a_timed_out;
  logic [7:0]  a_mem_addr, a_mem_din, a_pc_set_val, a_instr_count;
  logic [15:0] a_cycle_count;
  logic        b_cmd_ready, b_mem_we, b_pc_set_wr, b_run, b_busy, b_finished, b_timed_out;
  logic [7:0]  b_mem_addr, b_mem_din, b_pc_set_val, b_instr_count;
  logic [15:0] b_cycle_count;

  simproc_run_ctrl #(.TIMEOUT(16'(TMO_A))) u_a (
    .clk(clk), .rst(cur.rst), .cmd_valid(cur.valid), .cmd_ready(a_cmd_ready),
    .cmd_op(cur.op), .cmd_addr(cur.addr), .cmd_data(cur.data),
    .proc_mem_addr(cur.pa), .proc_mem_din(cur.pd), .proc_mem_we(cur.pwe),
    .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_we(a_mem_we),
    .pc_set_val(a_pc_set_val), .pc_set_wr(a_pc_set_wr), .run(a_run),
    .halt(cur.halt), .done(cur.done), .busy(a_busy), .finished(a_finished),
    .timed_out(a_timed_out), .cycle_count(a_cycle_count), .instr_count(a_instr_count)
  );

  simproc_run_ctrl #(.TIMEOUT(16'(TMO_B))) u_b (
    .clk(clk), .rst(cur.rst), .cmd_valid(cur.valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cur.op), .cmd_addr(cur.addr), .cmd_data(cur.data),
    .proc_mem_addr(cur.pa), .proc_mem_din(cur.pd), .proc_mem_we(cur.pwe),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_we(b_mem_we),
    .pc_set_val(b_pc_set_val), .pc_set_wr(b_pc_set_wr), .run(b_run),
    .halt(cur.halt), .done(cur.done), .busy(b_busy), .finished(b_finished),
    .timed_out(b_timed_out), .cycle_count(b_cycle_count), .instr_count(b_instr_count)
  );

  assign out_a = {a_cmd_ready, a_mem_addr, a_mem_din, a_mem_we, a_pc_set_val, a_pc_set_wr,
                  a_run, a_busy, a_finished, a_timed_out, a_cycle_count, a_instr_count};
  assign out_b = {b_cmd_ready, b_mem_addr, b_mem_din, b_mem_we, b_pc_set_val, b_pc_set_wr,
                  b_run, b_busy, b_finished, b_timed_out, b_cycle_count, b_instr_count};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.ph = P_IDLE; m.addr = 8'h00; m.data = 8'h00; m.cycles = 0; m.instrs = 0;
    return m;
  endfunction

  function automatic out_t model_out(model_t m, in_t i);
    out_t o;
    o = '0;
    if (i.rst) return o;
    o.cmd_ready   = !(m.ph == P_WRITING || m.ph == P_SETTING);
    o.busy        = (m.ph == P_WRITING || m.ph == P_SETTING || m.ph == P_RUNNING);
    o.run         = (m.ph == P_RUNNING);
    o.finished    = (m.ph == P_HALTED);
    o.timed_out   = (m.ph == P_EXPIRED);
    o.pc_set_wr   = (m.ph == P_SETTING);
    o.pc_set_val  = (m.ph == P_SETTING) ? m.addr : 8'h00;
    o.cycle_count = 16'(m.cycles);
    o.instr_count = 8'(m.instrs);
    if (m.ph == P_WRITING) begin
      o.mem_we = 1'b1; o.mem_addr = m.addr; o.mem_din = m.data;
    end else if (m.ph == P_RUNNING) begin
      o.mem_we = i.pwe; o.mem_addr = i.pa; o.mem_din = i.pd;
    end
    return o;
  endfunction

  function automatic model_t model_next(model_t m, in_t i, int tmo);
    model_t n;
    logic acc;
    if (i.rst) return model_reset();
    n   = m;
    acc = i.valid && !(m.ph == P_WRITING || m.ph == P_SETTING);
    case (m.ph)
      P_IDLE: begin
        if (acc && i.op == 2'b00) begin n.addr = i.addr; n.data = i.data; n.ph = P_WRITING; end
        else if (acc && i.op == 2'b01) begin n.addr = i.addr; n.ph = P_SETTING; end
      end
      P_WRITING: n.ph = P_IDLE;
      P_SETTING: begin n.cycles = 0; n.instrs = 0; n.ph = P_RUNNING; end
      P_RUNNING: begin
        n.cycles = (m.cycles + 1 > 65535) ? 65535 : m.cycles + 1;
        if (i.done) n.instrs = (m.instrs + 1 > 255) ? 255 : m.instrs + 1;
        if (i.halt)                     n.ph = P_HALTED;
        else if (m.cycles == tmo - 1)   n.ph = P_EXPIRED;
        else if (acc && i.op == 2'b11)  n.ph = P_EXPIRED;
      end
      default: if (acc && i.op == 2'b10) n.ph = P_IDLE;
    endcase
    return n;
  endfunction

  function automatic in_t mk_in(logic rst, logic valid, logic [1:0] op, logic [7:0] addr,
                                logic [7:0] data, logic pwe, logic [7:0] pa, logic [7:0] pd,
                                logic halt, logic done);
    in_t v;
    v.rst = rst; v.valid = valid; v.op = op; v.addr = addr; v.data = data;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.halt = halt; v.done = done;
    return v;
  endfunction

  function automatic in_t idle_in();
    return mk_in(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endfunction

  function automatic in_t cmd_in(logic [1:0] op, logic [7:0] addr, logic [7:0] data);
    return mk_in(1'b0, 1'b1, op, addr, data, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endfunction

  function automatic in_t rst_in();
    return mk_in(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endfunction

  // Drive inputs, then compare both instances against the model mid-cycle.
  task automatic apply(input in_t v);
    cur = v;
    @(negedge clk);
    check("model_a", 64'(out_a), 64'(model_out(ma, cur)));
    check("model_b", 64'(out_b), 64'(model_out(mb, cur)));
  endtask

  task automatic advance();
    ma = model_next(ma, cur, TMO_A);
    mb = model_next(mb, cur, TMO_B);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input in_t v);
    apply(v);
    advance();
  endtask

  task automatic start_run(input logic [7:0] pc);
    tick(rst_in());
    tick(cmd_in(2'b01, pc, 8'h00));
    tick(idle_in());
  endtask

  vec_t vecs[12];
  in_t  v;

  initial begin
    cur = rst_in();
    ma  = model_reset();
    mb  = model_reset();

    vecs[0]  = '{mk_in(1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0), 0, 0, 8'h00, 8'h00, 0, 0};
    vecs[1]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 1, 8'h55, 8'h66, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};
    vecs[2]  = '{mk_in(0, 1, 2'b00, 8'h03, 8'hA8, 0, 8'h00, 8'h00, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};
    vecs[3]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0), 0, 1, 8'h03, 8'hA8, 1, 0};
    vecs[4]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};
    vecs[5]  = '{mk_in(0, 1, 2'b01, 8'h40, 8'h00, 0, 8'h00, 8'h00, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};
    vecs[6]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 1, 8'h11, 8'h22, 0, 0), 0, 0, 8'h00, 8'h00, 1, 0};
    vecs[7]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 1, 8'h77, 8'h99, 0, 0), 1, 1, 8'h77, 8'h99, 1, 1};
    vecs[8]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h12, 8'h34, 1, 0), 1, 0, 8'h12, 8'h34, 1, 1};
    vecs[9]  = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 1, 8'h77, 8'h99, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};
    vecs[10] = '{mk_in(0, 1, 2'b10, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};
    vecs[11] = '{mk_in(0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0), 1, 0, 8'h00, 8'h00, 0, 0};

    foreach (vecs[k]) begin
      apply(vecs[k].stim);
      check($sformatf("vec%0d", k),
            64'({a_cmd_ready, a_mem_we, a_mem_addr, a_mem_din, a_busy, a_run}),
            64'({vecs[k].ready, vecs[k].we, vecs[k].maddr, vecs[k].mdin, vecs[k].busy, vecs[k].run}));
      advance();
    end

    // Halt on the 12th RUN cycle after four done pulses.
    tick(rst_in());
    tick(cmd_in(2'b01, 8'h00, 8'h00));
    apply(idle_in());
    check("setpc_wr", 64'(a_pc_set_wr), 64'd1);
    check("setpc_val", 64'(a_pc_set_val), 64'h00);
    advance();
    for (int c = 1; c <= 12; c++) begin
      v = idle_in();
      v.done = (c == 3 || c == 5 || c == 7 || c == 9);
      v.halt = (c == 12);
      apply(v);
      check("run_on", 64'(a_run), 64'd1);
      advance();
    end
    apply(idle_in());
    check("fin_finished", 64'(a_finished), 64'd1);
    check("fin_run", 64'(a_run), 64'd0);
    check("fin_cycles", 64'(a_cycle_count), 64'd12);
    check("fin_instrs", 64'(a_instr_count), 64'd4);
    advance();
    apply(cmd_in(2'b10, 8'h00, 8'h00));
    check("clear_ready", 64'(a_cmd_ready), 64'd1);
    advance();
    apply(idle_in());
    check("clear_finished", 64'(a_finished), 64'd0);
    check("clear_busy", 64'(a_busy), 64'd0);
    advance();

    // Timeout after TMO_B cycles with no halt.
    start_run(8'h21);
    for (int c = 1; c <= TMO_B; c++) tick(idle_in());
    apply(idle_in());
    check("tout_flag", 64'(b_timed_out), 64'd1);
    check("tout_cycles", 64'(b_cycle_count), 64'd8);
    check("tout_run", 64'(b_run), 64'd0);
    advance();

    // Halt coincides with the last allowed cycle: halt wins.
    start_run(8'h22);
    for (int c = 1; c < TMO_B; c++) tick(idle_in());
    v = idle_in();
    v.halt = 1'b1;
    tick(v);
    apply(idle_in());
    check("race_finished", 64'(b_finished), 64'd1);
    check("race_timed_out", 64'(b_timed_out), 64'd0);
    check("race_cycles", 64'(b_cycle_count), 64'd8);
    advance();

    // Host ABORT during RUN.
    start_run(8'h30);
    tick(idle_in());
    tick(idle_in());
    tick(cmd_in(2'b11, 8'h00, 8'h00));
    apply(idle_in());
    check("abort_tout", 64'(a_timed_out), 64'd1);
    check("abort_cycles", 64'(a_cycle_count), 64'd3);
    advance();

    // Reset pulse in the middle of RUN, then in the middle of WR.
    start_run(8'h44);
    for (int c = 0; c < 3; c++) tick(idle_in());
    apply(rst_in());
    check("rst_run", 64'(a_run), 64'd0);
    check("rst_cycles", 64'(a_cycle_count), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_ready", 64'(a_cmd_ready), 64'd0);
    advance();
    apply(idle_in());
    check("post_rst_ready", 64'(a_cmd_ready), 64'd1);
    advance();
    tick(cmd_in(2'b00, 8'h5A, 8'hC3));
    apply(rst_in());
    check("rst_wr_we", 64'(a_mem_we), 64'd0);
    check("rst_wr_addr", 64'(a_mem_addr), 64'h00);
    advance();

    // Random traffic against the model on both instances.
    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(0, 199) == 0);
      v.valid = 1'($urandom_range(0, 1));
      v.op    = 2'($urandom_range(0, 3));
      v.addr  = 8'($urandom);
      v.data  = 8'($urandom);
      v.pwe   = 1'($urandom_range(0, 1));
      v.pa    = 8'($urandom);
      v.pd    = 8'($urandom);
      v.halt  = ($urandom_range(0, 24) == 0);
      v.done  = 1'($urandom_range(0, 1));
      tick(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/simproc_run_ctrl.md
SIMPROC_RUN_CTRL -- requirements
Module: simproc_run_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1000, max RUN cycles before forced stop.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  host command valid.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when valid&ready at posedge.
REQ-006 SHALL have port cmd_op  input  2  command: 00 WRITE, 01 START, 10 CLEAR, 11 ABORT.
REQ-007 SHALL have port cmd_addr  input  8  memory address (WRITE) or start PC (START).
REQ-008 SHALL have port cmd_data  input  8  write data (WRITE).
REQ-009 SHALL have ports proc_mem_addr / proc_mem_din / proc_mem_we  input  8/8/1  processor memory request.
REQ-010 SHALL have ports mem_addr / mem_din / mem_we  output  8/8/1  muxed request to the single-port memory.
REQ-011 SHALL have ports pc_set_val / pc_set_wr / run  output  8/1/1  processor control.
REQ-012 SHALL have ports halt / done  input  1/1  processor halted / instruction-complete pulse.
REQ-013 SHALL have ports busy / finished / timed_out  output  1/1/1  status.
REQ-014 SHALL have ports cycle_count / instr_count  output  16/8  run statistics.

Function
REQ-015 SHALL implement states IDLE, WR, SETPC, RUN, FIN, TOUT.
REQ-016 cmd_ready SHALL be 1 in IDLE, RUN, FIN and TOUT; 0 in WR and SETPC.
REQ-017 IDLE: accepted WRITE -> WR; START -> SETPC; CLEAR/ABORT consumed, no effect.
REQ-018 WR (1 cycle): mem_we=1, mem_addr=captured cmd_addr, mem_din=captured cmd_data; then -> IDLE.
REQ-019 SETPC (1 cycle): pc_set_wr=1, pc_set_val=captured cmd_addr; cycle_count and instr_count cleared to 0; then -> RUN.
REQ-020 RUN: run=1; memory outputs SHALL equal proc_mem_* combinationally; in all other states mem_we=0 unless WR, and proc_mem_we SHALL be ignored.
REQ-021 RUN: cycle_count +1 per cycle, saturating at 16'hFFFF; instr_count +1 per cycle with done=1, saturating at 8'hFF.
REQ-022 RUN: halt=1 -> FIN; else cycle_count==TIMEOUT-1 -> TOUT; accepted ABORT -> TOUT; other ops consumed, ignored.
REQ-023 halt and timeout (or ABORT) in same cycle: halt SHALL win, -> FIN.
REQ-024 FIN/TOUT: counters hold; accepted CLEAR -> IDLE; other ops consumed, ignored.
REQ-025 busy=1 in WR, SETPC, RUN; finished=1 in FIN; timed_out=1 in TOUT; all registered from state.
REQ-026 run SHALL deassert in the first FIN/TOUT cycle; pc_set_wr SHALL be 1 only in SETPC.
REQ-027 Outside WR and RUN, mem_addr and mem_din SHALL be 0.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, counters 0, run=0, pc_set_wr=0, mem_we=0, pc_set_val=0, busy/finished/timed_out=0.
REQ-029 cmd_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-030 rst asserted mid-RUN or mid-WR SHALL abort with no memory write completing after assertion.

Verification
REQ-031 WRITE addr=8'h03 data=8'hA8 -> one cycle mem_we=1, mem_addr=03, mem_din=A8, cmd_ready=0 that cycle, then IDLE.
REQ-032 START addr=8'h00, halt raised on 12th RUN cycle with 4 done pulses -> pc_set_wr pulse val=00, FIN, cycle_count=12, instr_count=4.
REQ-033 START with TIMEOUT=8, halt never asserted -> TOUT after 8 RUN cycles, cycle_count=8, run=0.
REQ-034 halt and cycle_count==TIMEOUT-1 same cycle -> FIN, timed_out=0.
REQ-035 proc_mem_we=1 in IDLE -> mem_we=0; in RUN -> mem_we=1 with proc_mem_addr passed through.
REQ-036 rst pulse during RUN -> immediate IDLE, run=0, counters 0; FIN then CLEAR -> IDLE, finished=0.
